// File: rtl/definitions.sv
// Shared types, round constants and round-function helpers for the SHA-256
// round sequencer and its datapath.
package definitions;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned HASH_WORDS = 8;
   localparam int unsigned TEMP_WORDS = 3;
   localparam int unsigned K_DEPTH    = 64;
   localparam int unsigned IDX_W      = 8;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      PRECOMPUTE,
      KERNEL,
      EPILOGUE,
      CHUNK_DONE
   } round_type_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRECOMP,
      S_KERNEL,
      S_EPILOGUE,
      S_FINAL
   } sha256_state_t;

   localparam word_t K [0:K_DEPTH-1] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam word_t H_INIT [0:HASH_WORDS-1] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic word_t big_sigma0(input word_t x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic word_t big_sigma1(input word_t x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic word_t ch(input word_t e, input word_t f, input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t maj(input word_t a, input word_t b, input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_hash_function.sv
// Combinational SHA-256 round datapath. temp[0] carries h+wk and temp[1]
// carries d+h+wk for the coming round, so the round itself never adds wk.
module sha256_hash_function
   import definitions::*;
(
   input  round_type_t round_type,
   input  word_t       wk,
   input  word_t       inter_in  [0:HASH_WORDS-1],
   input  word_t       temp_in   [0:TEMP_WORDS-1],
   output word_t       inter_out [0:HASH_WORDS-1],
   output word_t       temp_out  [0:TEMP_WORDS-1]
);

   word_t e_part;
   word_t a_part;
   word_t t1_full;

   always_comb begin
      e_part    = big_sigma1(inter_in[4]) + ch(inter_in[4], inter_in[5], inter_in[6]);
      a_part    = big_sigma0(inter_in[0]) + maj(inter_in[0], inter_in[1], inter_in[2]);
      t1_full   = temp_in[0] + e_part;
      inter_out = inter_in;
      temp_out  = temp_in;

      case (round_type)
         PRECOMPUTE: begin
            temp_out[0] = inter_in[7] + wk;
            temp_out[1] = inter_in[3] + inter_in[7] + wk;
            temp_out[2] = '0;
         end
         KERNEL, EPILOGUE: begin
            inter_out[0] = t1_full + a_part;
            inter_out[1] = inter_in[0];
            inter_out[2] = inter_in[1];
            inter_out[3] = inter_in[2];
            inter_out[4] = temp_in[1] + e_part;
            inter_out[5] = inter_in[4];
            inter_out[6] = inter_in[5];
            inter_out[7] = inter_in[6];
            // next round's h is today's g and its d is today's c
            temp_out[0]  = (round_type == KERNEL) ? inter_in[6] + wk : '0;
            temp_out[1]  = (round_type == KERNEL) ? inter_in[2] + inter_in[6] + wk : '0;
            temp_out[2]  = t1_full;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/sha256_round_sequencer.sv
// Drives one 512-bit chunk through the SHA-256 round datapath, one round per
// consumed schedule word, then folds the result into the incoming hash state.
module sha256_round_sequencer
   import definitions::*;
#(
   parameter int unsigned NUM_ROUNDS = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  word_t            h_in   [0:HASH_WORDS-1],
   input  word_t            w_in,
   input  logic             w_valid,
   output logic             w_ready,
   output logic             busy,
   output logic [IDX_W-1:0] round_idx,
   output word_t            digest [0:HASH_WORDS-1],
   output logic             digest_valid
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

   sha256_state_t state;
   round_type_t   round_type;
   word_t         work     [0:HASH_WORDS-1];
   word_t         temps    [0:TEMP_WORDS-1];
   word_t         h_save   [0:HASH_WORDS-1];
   word_t         dp_inter [0:HASH_WORDS-1];
   word_t         dp_temp  [0:TEMP_WORDS-1];
   word_t         wk;
   logic          consume;
   logic          advance;

   // Round-type select, K lookup and the handshake qualifiers.
   always_comb begin
      round_type = CHUNK_DONE;
      case (state)
         S_PRECOMP:  round_type = PRECOMPUTE;
         S_KERNEL:   round_type = KERNEL;
         S_EPILOGUE: round_type = EPILOGUE;
         default:    round_type = CHUNK_DONE;
      endcase
      consume = w_valid & w_ready;
      advance = consume | (state == S_EPILOGUE);
      wk      = w_in + K[round_idx[5:0]];
   end

   sha256_hash_function u_hash (
      .round_type (round_type),
      .wk         (wk),
      .inter_in   (work),
      .temp_in    (temps),
      .inter_out  (dp_inter),
      .temp_out   (dp_temp)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         busy         <= 1'b0;
         w_ready      <= 1'b0;
         digest_valid <= 1'b0;
         round_idx    <= '0;
         for (int i = 0; i < HASH_WORDS; i++) begin
            work[i]   <= '0;
            h_save[i] <= '0;
            digest[i] <= '0;
         end
         for (int i = 0; i < TEMP_WORDS; i++) begin
            temps[i] <= '0;
         end
      end else begin
         digest_valid <= 1'b0;

         // stalled cycles leave every working register untouched
         if (advance) begin
            work  <= dp_inter;
            temps <= dp_temp;
         end
         if (consume) begin
            round_idx <= round_idx + IDX_W'(1);
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_PRECOMP;
                  busy      <= 1'b1;
                  w_ready   <= 1'b1;
                  round_idx <= '0;
                  work      <= h_in;
                  h_save    <= h_in;
                  for (int i = 0; i < TEMP_WORDS; i++) begin
                     temps[i] <= '0;
                  end
               end
            end
            S_PRECOMP: begin
               if (consume) begin
                  if (round_idx == LAST_IDX) begin
                     state   <= S_EPILOGUE;
                     w_ready <= 1'b0;
                  end else begin
                     state <= S_KERNEL;
                  end
               end
            end
            S_KERNEL: begin
               if (consume && (round_idx == LAST_IDX)) begin
                  state   <= S_EPILOGUE;
                  w_ready <= 1'b0;
               end
            end
            S_EPILOGUE: begin
               state <= S_FINAL;
            end
            S_FINAL: begin
               for (int i = 0; i < HASH_WORDS; i++) begin
                  digest[i] <= h_save[i] + work[i];
               end
               digest_valid <= 1'b1;
               busy         <= 1'b0;
               state        <= S_IDLE;
            end
            default: begin
               state   <= S_IDLE;
               busy    <= 1'b0;
               w_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
